// File: rtl/img_sram_ctrl.sv
// img_sram_ctrl: sequences read/write/burst requests onto the image SRAM pins and
// buffers read data on a backpressured response stream.
module img_sram_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ROW_W     = 8,
    parameter int COL_W     = 8,
    parameter int LEN_W     = 16,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ROW_W-1:0]  req_row,
    input  logic [COL_W-1:0]  req_col,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              sram_write_en,
    output logic              sram_sense_en,
    output logic [ROW_W-1:0]  sram_row,
    output logic [COL_W-1:0]  sram_col,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              busy
);
    localparam int ADDR_W = ROW_W + COL_W;
    localparam int PTR_W  = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
    localparam int OCC_W  = CNT_W + 1;
    localparam logic [1:0] OP_RD    = 2'b00;
    localparam logic [1:0] OP_WR    = 2'b01;
    localparam logic [1:0] OP_BURST = 2'b10;

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state, state_nxt;
    logic                rdy_en;
    logic                inflight, inflight_last;
    logic [CNT_W-1:0]    count;
    logic [OCC_W-1:0]    occ;
    logic [PTR_W-1:0]    rd_ptr, wr_ptr;
    logic [DATA_W-1:0]   buf_data [RSP_DEPTH];
    logic [RSP_DEPTH-1:0] buf_last;
    logic [LEN_W-1:0]    remaining;
    logic [ROW_W-1:0]    cur_row;
    logic [COL_W-1:0]    cur_col;
    logic [ADDR_W-1:0]   rd_addr;
    logic                pop, can_issue, acc, burst_issue, burst_end;
    logic                issue_rd, issue_wr, issue_last;

    function automatic logic [PTR_W-1:0] nxt_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        rsp_valid   = count != '0;
        pop         = rsp_valid & rsp_ready;
        // occupancy the buffer will have once this cycle's capture/pop settle
        occ         = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
        can_issue   = occ < OCC_W'(RSP_DEPTH);
        req_ready   = rdy_en & (state == IDLE) & can_issue;
        acc         = req_valid & req_ready;
        burst_issue = (state == BURST) & can_issue;
        burst_end   = remaining == LEN_W'(1);
        issue_wr    = acc & (req_op == OP_WR);
        issue_rd    = (acc & (req_op == OP_RD || req_op == OP_BURST)) | burst_issue;
        issue_last  = (state == BURST) ? burst_end : (req_op == OP_RD || req_len == '0);
        rd_addr     = (state == BURST) ? {cur_row, cur_col} : {req_row, req_col};
        state_nxt   = state;
        if (acc && req_op == OP_BURST && req_len != '0)
            state_nxt = BURST;
        if (burst_issue && burst_end)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdy_en        <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            count         <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            buf_last      <= '0;
            remaining     <= '0;
            cur_row       <= '0;
            cur_col       <= '0;
            sram_write_en <= 1'b0;
            sram_sense_en <= 1'b1;
            sram_row      <= '0;
            sram_col      <= '0;
            sram_din      <= '0;
            for (int i = 0; i < RSP_DEPTH; i++)
                buf_data[i] <= '0;
        end else begin
            rdy_en        <= 1'b1;
            inflight      <= issue_rd;
            inflight_last <= issue_last;
            sram_write_en <= issue_wr;
            sram_sense_en <= ~issue_rd;
            if (issue_wr) begin
                sram_row <= req_row;
                sram_col <= req_col;
                sram_din <= req_wdata;
            end else if (issue_rd) begin
                sram_row <= rd_addr[ADDR_W-1:COL_W];
                sram_col <= rd_addr[COL_W-1:0];
            end
            // row-major advance; the concatenated increment wraps col into row and row to 0
            if (issue_rd)
                {cur_row, cur_col} <= rd_addr + ADDR_W'(1);
            if (acc && req_op == OP_BURST)
                remaining <= req_len;
            else if (burst_issue)
                remaining <= remaining - 1'b1;
            if (inflight) begin
                buf_data[wr_ptr] <= sram_dout;
                buf_last[wr_ptr] <= inflight_last;
                wr_ptr           <= nxt_ptr(wr_ptr);
            end
            if (pop)
                rd_ptr <= nxt_ptr(rd_ptr);
            count <= count + CNT_W'(inflight) - CNT_W'(pop);
        end
    end

    assign rsp_data = buf_data[rd_ptr];
    assign rsp_last = buf_last[rd_ptr];
    assign busy     = (state == BURST) | inflight | rsp_valid;
endmodule

// File: tb/tb_img_sram_ctrl.sv
// tb_img_sram_ctrl: directed table, corner sequences and random traffic checked
// against a flat-memory reference model and an SRAM pin model.
module tb_img_sram_ctrl;
    logic        clk = 0, rst_n = 0;
    logic        req_valid = 0, req_ready;
    logic [1:0]  req_op = 0;
    logic [7:0]  req_row = 0, req_col = 0, req_wdata = 0;
    logic [15:0] req_len = 0;
    logic        rsp_valid, rsp_ready, rsp_last;
    logic [7:0]  rsp_data;
    logic        sram_write_en, sram_sense_en;
    logic [7:0]  sram_row, sram_col, sram_din;
    logic [7:0]  sram_dout = 0;
    logic        busy;

    img_sram_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .sram_write_en(sram_write_en), .sram_sense_en(sram_sense_en),
        .sram_row(sram_row), .sram_col(sram_col), .sram_din(sram_din),
        .sram_dout(sram_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return (a[7:0] * 8'd37) ^ a[15:8] ^ 8'h5C;
    endfunction

    typedef struct {
        int         cyc;
        logic [7:0] row, col, d;
        logic       last;
    } ev_t;

    typedef struct packed {
        logic [1:0]      op;
        logic [7:0]      row, col, wd;
        logic [15:0]     len;
        logic [2:0]      n;
        logic [3:0][7:0] er, ec, ed;
    } vec_t;

    int   cyc = 0;
    int   rr_mode = 0;
    ev_t  rd_log[$], wr_log[$], rsp_log[$];
    ev_t  mon_e;
    int   stall_err = 0, pin_err = 0;
    logic prev_stall = 0, prev_l = 0;
    logic [7:0] prev_d = 0;
    logic [7:0] sram_mem [65536];

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM pin model: acts during clk low
    initial begin
        for (int i = 0; i < 65536; i++) sram_mem[i] = pat(16'(i));
        forever begin
            @(negedge clk);
            if (sram_write_en === 1'b1) sram_mem[{sram_row, sram_col}] = sram_din;
            if (sram_sense_en === 1'b0) sram_dout = sram_mem[{sram_row, sram_col}];
        end
    end

    initial begin
        rsp_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = rr_mode == 0 ? 1'b1 : rr_mode == 1 ? 1'($urandom_range(0, 1)) : 1'((cyc % 3) == 0);
        end
    end

    always @(negedge clk) begin
        mon_e.cyc = cyc; mon_e.row = sram_row; mon_e.col = sram_col; mon_e.d = sram_din; mon_e.last = 0;
        if (sram_sense_en === 1'b0) rd_log.push_back(mon_e);
        if (sram_write_en === 1'b1) wr_log.push_back(mon_e);
        if (sram_write_en === 1'b1 && sram_sense_en === 1'b0) pin_err++;
        mon_e.d = rsp_data; mon_e.last = rsp_last;
        if (rsp_valid === 1'b1 && rsp_ready) rsp_log.push_back(mon_e);
        if (prev_stall && rsp_valid === 1'b1 && (rsp_data !== prev_d || rsp_last !== prev_l)) stall_err++;
        prev_stall = rsp_valid === 1'b1 && !rsp_ready;
        prev_d = rsp_data;
        prev_l = rsp_last;
    end

    int          checks = 0, failures = 0;
    int          acc_cyc = 0, rsp_base = 0;
    logic [7:0]  ref_mem [65536];
    logic [8:0]  exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [1:0] op, input logic [7:0] r, c, wd, input logic [15:0] len);
        int t = 0;
        bit ok = 0;
        logic [15:0] a;
        req_valid = 1; req_op = op; req_row = r; req_col = c; req_wdata = wd; req_len = len;
        while (!ok && t < 100) begin
            @(negedge clk);
            ok = req_ready === 1'b1;
            step();
            t++;
        end
        req_valid = 0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL req_accept: got timeout expected handshake");
            return;
        end
        acc_cyc = cyc;
        a = {r, c};
        if (op == 2'd0) exp_q.push_back({1'b1, ref_mem[a]});
        if (op == 2'd1) ref_mem[a] = wd;
        if (op == 2'd2)
            for (int k = 0; k <= int'(len); k++) exp_q.push_back({k == int'(len), ref_mem[16'(a + k)]});
    endtask

    task automatic drain();
        int t = 0;
        while ((rsp_log.size() - rsp_base < exp_q.size() || busy !== 1'b0) && t < 400) begin
            step();
            t++;
        end
        step();
        step();
        chk("rsp_count", rsp_log.size() - rsp_base, exp_q.size());
        for (int i = 0; i < exp_q.size() && rsp_base + i < rsp_log.size(); i++)
            chk("rsp_model", {rsp_log[rsp_base + i].last, rsp_log[rsp_base + i].d}, exp_q[i]);
        rsp_base = rsp_log.size();
        exp_q.delete();
    endtask

    task automatic chk_reset();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_last", rsp_last, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_write_en", sram_write_en, 0);
        chk("rst_sense_en", sram_sense_en, 1);
        chk("rst_row_col_din", {sram_row, sram_col, sram_din}, 0);
    endtask

    initial begin
        vec_t tbl[7];
        vec_t tv;
        int   rb, wb, sb, t, np;
        for (int i = 0; i < 65536; i++) ref_mem[i] = pat(16'(i));
        tbl[0] = {2'd1, 8'd3, 8'd7, 8'hA5, 16'd0, 3'd1, 32'd3, 32'd7, 32'hA5};
        tbl[1] = {2'd0, 8'd3, 8'd7, 8'h00, 16'd0, 3'd1, 32'd3, 32'd7, 32'hA5};
        tbl[2] = {2'd2, 8'd0, 8'd254, 8'h00, 16'd3, 3'd4, {8'd1, 8'd1, 8'd0, 8'd0},
                  {8'd1, 8'd0, 8'd255, 8'd254}, {pat(16'h0101), pat(16'h0100), pat(16'h00FF), pat(16'h00FE)}};
        tbl[3] = {2'd2, 8'd255, 8'd255, 8'h00, 16'd1, 3'd2, {8'd0, 8'd0, 8'd0, 8'd255},
                  {8'd0, 8'd0, 8'd0, 8'd255}, {8'd0, 8'd0, pat(16'h0000), pat(16'hFFFF)}};
        tbl[4] = {2'd3, 8'd3, 8'd7, 8'h77, 16'd5, 3'd0, 32'd0, 32'd0, 32'd0};
        tbl[5] = {2'd0, 8'd5, 8'd5, 8'h00, 16'd0, 3'd1, 32'd5, 32'd5, {24'd0, pat(16'h0505)}};
        tbl[6] = {2'd2, 8'd7, 8'd9, 8'h00, 16'd0, 3'd1, 32'd7, 32'd9, {24'd0, pat(16'h0709)}};

        repeat (3) step();
        @(negedge clk);
        chk_reset();
        step();
        rst_n = 1;
        step();
        chk("ready_after_reset", req_ready, 1);

        for (int v = 0; v < 7; v++) begin
            tv = tbl[v];
            rb = rd_log.size(); wb = wr_log.size(); sb = rsp_log.size();
            do_req(tv.op, tv.row, tv.col, tv.wd, tv.len);
            drain();
            if (tv.op == 2'd1) begin
                chk("wr_count", wr_log.size() - wb, 1);
                if (wr_log.size() > wb) begin
                    chk("wr_pins", {wr_log[wb].row, wr_log[wb].col, wr_log[wb].d}, {tv.er[0], tv.ec[0], tv.ed[0]});
                    chk("wr_cycle", wr_log[wb].cyc, acc_cyc);
                end
            end else begin
                chk("wr_none", wr_log.size() - wb, 0);
                chk("rd_count", rd_log.size() - rb, tv.n);
                chk("rsp_cnt", rsp_log.size() - sb, tv.n);
                for (int k = 0; k < int'(tv.n); k++) begin
                    if (rb + k < rd_log.size()) begin
                        chk("rd_addr", {rd_log[rb + k].row, rd_log[rb + k].col}, {tv.er[k], tv.ec[k]});
                        chk("rd_cycle", rd_log[rb + k].cyc, acc_cyc + k);
                    end
                    if (sb + k < rsp_log.size()) begin
                        chk("rsp_data", rsp_log[sb + k].d, tv.ed[k]);
                        chk("rsp_last", rsp_log[sb + k].last, k == int'(tv.n) - 1);
                        chk("rsp_cycle", rsp_log[sb + k].cyc, acc_cyc + 1 + k);
                    end
                end
            end
        end

        // back-to-back writes then a burst reading them back
        wb = wr_log.size();
        for (int k = 0; k < 4; k++) do_req(2'd1, 8'd12, 8'(k), 8'(8'h10 + k), 16'd0);
        step();
        chk("b2b_wr_count", wr_log.size() - wb, 4);
        for (int k = 0; k < 4 && wb + k < wr_log.size(); k++)
            chk("b2b_wr", {wr_log[wb + k].cyc - wr_log[wb].cyc, wr_log[wb + k].col, wr_log[wb + k].d},
                {32'(k), 8'(k), 8'(8'h10 + k)});
        sb = rsp_log.size();
        do_req(2'd2, 8'd12, 8'd0, 8'h00, 16'd3);
        drain();
        for (int k = 0; k < 4 && sb + k < rsp_log.size(); k++)
            chk("b2b_rsp", {rsp_log[sb + k].last, rsp_log[sb + k].d}, {k == 3, 8'(8'h10 + k)});

        // burst under periodic backpressure
        rr_mode = 2;
        rb = rd_log.size(); sb = rsp_log.size();
        do_req(2'd2, 8'd20, 8'd250, 8'h00, 16'd7);
        drain();
        chk("bp_rd_count", rd_log.size() - rb, 8);
        chk("bp_rsp_count", rsp_log.size() - sb, 8);
        for (int k = 0; k < 8 && rb + k < rd_log.size(); k++)
            chk("bp_rd_addr", {rd_log[rb + k].row, rd_log[rb + k].col}, 16'(16'd20 * 256 + 250 + k));
        for (int k = 0; k < 8 && sb + k < rsp_log.size(); k++)
            chk("bp_rsp", {rsp_log[sb + k].last, rsp_log[sb + k].d}, {k == 7, pat(16'(16'd20 * 256 + 250 + k))});
        if (rd_log.size() >= rb + 8) chk("bp_stalled", rd_log[rb + 7].cyc - rd_log[rb] .cyc > 7, 1);
        rr_mode = 0;
        step();

        // reset in the middle of a burst
        rb = rd_log.size();
        do_req(2'd2, 8'd40, 8'd0, 8'h00, 16'd7);
        t = 0;
        while (rd_log.size() < rb + 3 && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("mid_reads_seen", rd_log.size() - rb, 3);
        rst_n = 0;
        step();
        rst_n = 1;
        np = rsp_log.size() - rsp_base;
        for (int i = 0; i < np && i < exp_q.size(); i++)
            chk("pre_reset_rsp", {rsp_log[rsp_base + i].last, rsp_log[rsp_base + i].d}, exp_q[i]);
        rsp_base = rsp_log.size();
        exp_q.delete();
        @(negedge clk);
        chk_reset();
        repeat (6) step();
        chk("no_rsp_after_reset", rsp_log.size() - rsp_base, 0);
        chk("no_rd_after_reset", rd_log.size() - rb, 3);
        chk("ready_after_release", req_ready, 1);
        chk("idle_after_release", busy, 0);

        // random traffic against the reference model
        rr_mode = 1;
        for (int n = 0; n < 200; n++) begin
            int r;
            logic [7:0] row, col;
            r = $urandom_range(0, 9);
            row = ($urandom_range(0, 4) == 4) ? 8'hFF : 8'($urandom_range(0, 3));
            col = ($urandom_range(0, 3) == 3) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 7));
            do_req(r < 4 ? 2'd0 : r < 7 ? 2'd1 : r < 9 ? 2'd2 : 2'd3, row, col,
                   8'($urandom), 16'($urandom_range(0, 5)));
            repeat ($urandom_range(0, 2)) step();
        end
        drain();
        rr_mode = 0;
        chk("stall_stability", stall_err, 0);
        chk("pin_encoding", pin_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/img_sram_ctrl.md
Name: img_sram_ctrl

Overview:
- Sequencing controller in front of the image SRAM array.
- Converts a valid/ready request stream (single read, single write, burst row-major read) into SRAM pin activity, i.e. write_en/sense_en/row/col/din per cycle.
- Captures read data and returns it on a backpressured response stream through a small buffer.
- Successor to the fixed 256x256x8 wrapper: address and data widths are parametrised, and it adds burst reads with row wrap-around and flow control.

Parameters:
- DATA_W, 8, pixel word width.
- ROW_W, 8, row address bits (2^ROW_W rows).
- COL_W, 8, column address bits (2^COL_W columns).
- LEN_W, 16, burst length field width (length = req_len+1 words).
- RSP_DEPTH, 2, response buffer entries (>=2).

Ports:
- clk  in  1  single clock; the SRAM shares it and acts during clk low.
- rst_n  in  1  reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&ready at posedge.
- req_op  in  2  00 read, 01 write, 10 burst read, 11 reserved (accepted, ignored).
- req_row  in  ROW_W  start row.
- req_col  in  COL_W  start column.
- req_wdata  in  DATA_W  write data.
- req_len  in  LEN_W  burst words minus 1.
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  consumer ready.
- rsp_data  out  DATA_W  read word.
- rsp_last  out  1  final word of a read/burst.
- sram_write_en  out  1  to SRAM.
- sram_sense_en  out  1  to SRAM.
- sram_row  out  ROW_W  to SRAM.
- sram_col  out  COL_W  to SRAM.
- sram_din  out  DATA_W  to SRAM.
- sram_dout  in  DATA_W  from SRAM; valid at the posedge ending a read cycle.
- busy  out  1  burst active or read in flight.

Interface: one clock; reset is synchronous and active-low.

Behaviour:
- SRAM pin encoding, all outputs registered:
  - HOLD: write_en=0, sense_en=1.
  - WRITE: write_en=1, sense_en=1.
  - READ: write_en=0, sense_en=0.
  - Default every cycle is HOLD; row/col/din keep their last values.
- Reset values (posedge with rst_n=0):
  - req_ready=0, rsp_valid=0, rsp_last=0, rsp_data=0, busy=0.
  - sram_write_en=0, sram_sense_en=1, sram_row/col/din=0.
  - FSM=IDLE, buffer flushed, in-flight read discarded.
  - Reset mid-burst aborts the burst; no rsp_last is produced.
- FSM states: IDLE, BURST.
- req_ready: 1 in IDLE when buffer credit is available (credit rule below); 0 in BURST.
- Write accepted at edge N:
  - Pins = WRITE with row/col/din during cycle N..N+1.
  - HOLD from N+1 unless another write or read is accepted.
  - Back-to-back writes sustain 1 per cycle.
- Single read accepted at edge N:
  - Pins = READ in cycle N..N+1.
  - sram_dout captured into the buffer at edge N+1.
  - rsp_valid=1 from N+1 with rsp_last=1.
  - Latency request-to-rsp_valid = 1 cycle.
- Burst accepted at edge N:
  - Enter BURST; remaining = req_len+1.
  - Each cycle a read is issued if credit allows; col increments per issued read.
  - col wraps 2^COL_W-1 -> 0 with row+1; row wraps 2^ROW_W-1 -> 0.
  - The last issued read tags rsp_last; FSM returns to IDLE at the edge issuing it.
- Credit rule: issue a read (single or burst) only if count + inflight - pop < RSP_DEPTH.
  - pop = rsp_valid & rsp_ready this cycle.
  - inflight = read issued the previous cycle.
  - With rsp_ready held high, a burst streams 1 word/cycle.
  - The buffer never overflows; no word is dropped or duplicated.
- Response buffer: FIFO order.
  - rsp_data/rsp_last stable while rsp_valid & ~rsp_ready.
  - Simultaneous push and pop at full occupancy is legal.
- busy = (FSM==BURST) | inflight | rsp_valid.
- req_op=11: consumes one handshake, pins stay HOLD, no response.

Test Plan:
- Write 0xA5 to row 3, col 7, then read the same address: pins WRITE with row=3/col=7/din=0xA5 for one cycle; the read produces rsp_data=0xA5, rsp_last=1, rsp_valid one cycle after acceptance.
- Burst row=0, col=254, len=3 with rsp_ready=1: SRAM reads (0,254),(0,255),(1,0),(1,1) on consecutive cycles; 4 responses in order, rsp_last only on the 4th.
- Burst row=255, col=255, len=1: addresses (255,255) then (0,0).
- Burst len=7 with rsp_ready toggling 1,0,0,1,...: exactly 8 words in address order, no overflow; rsp_data held stable while stalled; sense_en=1 on stalled cycles.
- rst_n low for one edge mid-burst (3 of 8 words issued): outputs return to reset values the next cycle; no further responses; req_ready=1 after release.
- Back-to-back writes to cols 0..3 (data 0x10..0x13), then a len=3 burst from col 0: 4 WRITE cycles, then responses 0x10,0x11,0x12,0x13.
